// File: rtl/md_sched.sv
// md_sched: HI/LO multiply/divide sequencer for the 5-stage pipeline.
// Latency: mult/multu -> HI/LO MULT_CYC cycles after start edge; div/divu -> DIV_CYC; mthi/mtlo -> 1.
// Backpressure: stall_md holds ID md instructions while busy or on the start cycle; EX ops during RUN are ignored.
//
// Ports:
//   clk, reset       rising-edge clock, async active-low reset
//   ex_op            EX md op (1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, others none)
//   ex_cancel        EX instruction flushed this cycle; suppresses start and mthi/mtlo
//   ex_rs, ex_rt     forwarded operands of the EX instruction
//   id_md_use        ID instruction touches the HI/LO unit
//   start            mult/div accepted this cycle (combinational)
//   busy             unit computing (registered)
//   stall_md         freeze PC/IF/ID (combinational)
//   hi, lo           architectural HI/LO registers
module md_sched #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  ex_op,
  input  logic        ex_cancel,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        id_md_use,
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC - 1);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] hi_nxt, lo_nxt;
  logic [31:0] pend_hi, pend_lo, pend_hi_nxt, pend_lo_nxt;
  logic        pend_wr, pend_wr_nxt;

  // Arithmetic datapath; the result is captured into pend_* on the start edge
  // and only becomes architectural at completion.
  logic [63:0]        rs_sx, rt_sx, rs_zx, rt_zx;
  logic [63:0]        prod_s, prod_u;
  logic [31:0]        rt_safe;
  logic signed [31:0] rs_s, rt_s, quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;
  logic               div_zero;

  assign rs_sx  = {{32{ex_rs[31]}}, ex_rs};
  assign rt_sx  = {{32{ex_rt[31]}}, ex_rt};
  assign rs_zx  = {32'd0, ex_rs};
  assign rt_zx  = {32'd0, ex_rt};
  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_s = rs_sx * rt_sx;
  assign prod_u = rs_zx * rt_zx;

  // Divide-by-zero leaves HI/LO untouched; substitute 1 so the divider never sees 0.
  assign div_zero = (ex_rt == 32'd0);
  assign rt_safe  = div_zero ? 32'd1 : ex_rt;
  assign rs_s     = $signed(ex_rs);
  assign rt_s     = $signed(rt_safe);
  assign quot_s   = rs_s / rt_s;   // truncates toward zero
  assign rem_s    = rs_s % rt_s;   // takes sign of dividend
  assign quot_u   = ex_rs / rt_safe;
  assign rem_u    = ex_rs % rt_safe;

  assign busy     = (state == RUN);
  assign start    = (state == IDLE) && !ex_cancel &&
                    (ex_op == OP_MULT || ex_op == OP_MULTU ||
                     ex_op == OP_DIV  || ex_op == OP_DIVU);
  // Start cycle counts too: busy is not yet set when the op enters execution.
  assign stall_md = id_md_use && (busy || start);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hi_nxt      = hi;
    lo_nxt      = lo;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;
    pend_wr_nxt = pend_wr;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = RUN;
          pend_wr_nxt = 1'b1;
          case (ex_op)
            OP_MULT: begin
              cnt_nxt = MULT_LD;
              {pend_hi_nxt, pend_lo_nxt} = prod_s;
            end
            OP_MULTU: begin
              cnt_nxt = MULT_LD;
              {pend_hi_nxt, pend_lo_nxt} = prod_u;
            end
            OP_DIV: begin
              cnt_nxt     = DIV_LD;
              pend_lo_nxt = quot_s;
              pend_hi_nxt = rem_s;
              pend_wr_nxt = !div_zero;
            end
            default: begin
              cnt_nxt     = DIV_LD;
              pend_lo_nxt = quot_u;
              pend_hi_nxt = rem_u;
              pend_wr_nxt = !div_zero;
            end
          endcase
        end else if (!ex_cancel && ex_op == OP_MTHI) begin
          hi_nxt = ex_rs;
        end else if (!ex_cancel && ex_op == OP_MTLO) begin
          lo_nxt = ex_rs;
        end
      end
      RUN: begin
        // EX ops here are ignored; stall_md keeps them out in a legal pipeline.
        if (cnt == 4'd0) begin
          state_nxt = IDLE;
          if (pend_wr) begin
            hi_nxt = pend_hi;
            lo_nxt = pend_lo;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      hi      <= hi_nxt;
      lo      <= lo_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
      pend_wr <= pend_wr_nxt;
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: scoreboard bench for md_sched.
// Latency: expected HI/LO pushed at start, popped and compared when busy drops.
// Backpressure: stall_md and busy cycle counts compared against MULT_CYC/DIV_CYC.
module tb_md_sched;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic        clk;
  logic        reset;
  logic [2:0]  ex_op;
  logic        ex_cancel;
  logic [31:0] ex_rs;
  logic [31:0] ex_rt;
  logic        id_md_use;
  logic        start;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_sched #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .ex_op     (ex_op),
    .ex_cancel (ex_cancel),
    .ex_rs     (ex_rs),
    .ex_rt     (ex_rt),
    .id_md_use (id_md_use),
    .start     (start),
    .busy      (busy),
    .stall_md  (stall_md),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts busy cycles (and stalled ones) until busy drops, bounded.
  task automatic run_busy(output int bcyc, output int scyc);
    bcyc = 0;
    scyc = 0;
    while (busy === 1'b1 && bcyc < 40) begin
      bcyc++;
      if (stall_md === 1'b1) scyc++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; ex_op = 3'd0; ex_cancel = 1'b0;
    ex_rs = 32'd0; ex_rt = 32'd0; id_md_use = 1'b1;
    #2;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || start !== 1'b0 || stall_md !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got busy=%b hi=%h lo=%h start=%b stall=%b exp 0s",
               busy, hi, lo, start, stall_md);
    end
    tick();
    reset = 1'b1;
    id_md_use = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    int b, s;
    ex_op = 3'd1; ex_rs = 32'hFFFF_FFFE; ex_rt = 32'd3; #1;
    checks++;
    if (start !== 1'b1) begin errors++; $display("FAIL mult_start got %b exp 1", start); end
    sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFA});
    tick();
    // Op still on the bus while running: must not restart.
    checks++;
    if (start !== 1'b0) begin errors++; $display("FAIL mult_start_once got %b exp 0", start); end
    ex_op = 3'd0;
    run_busy(b, s);
    checks++;
    if (b != MULT_CYC) begin errors++; $display("FAIL mult_busy_cycles got %0d exp %0d", b, MULT_CYC); end
    e = sb.pop_front();
    checks++;
    if (hi !== e.hi || lo !== e.lo) begin
      errors++; $display("FAIL mult_result got %h_%h exp %h_%h", hi, lo, e.hi, e.lo);
    end
    m_hi = e.hi; m_lo = e.lo;
  endtask

  task automatic test_divu_stall();
    int b, s;
    id_md_use = 1'b1;
    ex_op = 3'd4; ex_rs = 32'd100; ex_rt = 32'd7; #1;
    checks++;
    if (start !== 1'b1 || stall_md !== 1'b1) begin
      errors++; $display("FAIL divu_start_stall got start=%b stall=%b exp 1 1", start, stall_md);
    end
    sb.push_back('{32'd2, 32'd14});
    tick();
    // A second div presented during RUN is ignored.
    ex_op = 3'd3; ex_rs = 32'd9; ex_rt = 32'd3;
    run_busy(b, s);
    ex_op = 3'd0;
    #1;
    checks++;
    if (b != DIV_CYC || s != DIV_CYC) begin
      errors++; $display("FAIL divu_busy_stall got busy=%0d stall=%0d exp %0d", b, s, DIV_CYC);
    end
    checks++;
    if (stall_md !== 1'b0) begin errors++; $display("FAIL divu_stall_release got %b exp 0", stall_md); end
    e = sb.pop_front();
    checks++;
    if (hi !== e.hi || lo !== e.lo) begin
      errors++; $display("FAIL divu_result got %h_%h exp %h_%h", hi, lo, e.hi, e.lo);
    end
    m_hi = e.hi; m_lo = e.lo;
    id_md_use = 1'b0;
  endtask

  task automatic test_div();
    int b, s;
    ex_op = 3'd3; ex_rs = 32'hFFFF_FFF9; ex_rt = 32'd2;
    sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFD});
    tick();
    ex_op = 3'd0;
    run_busy(b, s);
    e = sb.pop_front();
    checks++;
    if (hi !== e.hi || lo !== e.lo || b != DIV_CYC) begin
      errors++; $display("FAIL div_signed got %h_%h busy=%0d exp %h_%h busy=%0d",
                         hi, lo, b, e.hi, e.lo, DIV_CYC);
    end
    m_hi = e.hi; m_lo = e.lo;
    // Divide by zero: full busy time, HI/LO kept.
    ex_op = 3'd3; ex_rs = 32'd55; ex_rt = 32'd0;
    sb.push_back('{m_hi, m_lo});
    tick();
    ex_op = 3'd0;
    run_busy(b, s);
    e = sb.pop_front();
    checks++;
    if (hi !== e.hi || lo !== e.lo || b != DIV_CYC) begin
      errors++; $display("FAIL div_zero got %h_%h busy=%0d exp %h_%h busy=%0d",
                         hi, lo, b, e.hi, e.lo, DIV_CYC);
    end
  endtask

  task automatic test_cancel();
    id_md_use = 1'b1;
    ex_cancel = 1'b1; ex_op = 3'd1; ex_rs = 32'd7; ex_rt = 32'd9; #1;
    checks++;
    if (start !== 1'b0 || stall_md !== 1'b0) begin
      errors++; $display("FAIL cancel_mult_start got start=%b stall=%b exp 0 0", start, stall_md);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      errors++; $display("FAIL cancel_mult_state got busy=%b %h_%h exp 0 %h_%h", busy, hi, lo, m_hi, m_lo);
    end
    ex_op = 3'd5; ex_rs = 32'h0000_1234;
    tick();
    checks++;
    if (hi !== m_hi) begin errors++; $display("FAIL cancel_mthi got %h exp %h", hi, m_hi); end
    ex_cancel = 1'b0; ex_op = 3'd0; id_md_use = 1'b0;
  endtask

  task automatic test_mt();
    int b, s;
    ex_op = 3'd6; ex_rs = 32'h0000_ABCD;
    tick();
    ex_op = 3'd0;
    checks++;
    if (lo !== 32'h0000_ABCD || busy !== 1'b0) begin
      errors++; $display("FAIL mtlo got lo=%h busy=%b exp 0000abcd 0", lo, busy);
    end
    m_lo = 32'h0000_ABCD;
    ex_op = 3'd5; ex_rs = 32'h5555_AAAA;
    tick();
    ex_op = 3'd0;
    checks++;
    if (hi !== 32'h5555_AAAA || lo !== m_lo) begin
      errors++; $display("FAIL mthi got %h_%h exp 5555aaaa_%h", hi, lo, m_lo);
    end
    m_hi = 32'h5555_AAAA;
    // Unrelated instruction in ID while multiplying: no stall.
    id_md_use = 1'b0;
    ex_op = 3'd1; ex_rs = 32'd2; ex_rt = 32'd3; #1;
    checks++;
    if (stall_md !== 1'b0 || start !== 1'b1) begin
      errors++; $display("FAIL nostall_start got stall=%b start=%b exp 0 1", stall_md, start);
    end
    sb.push_back('{32'd0, 32'd6});
    tick();
    ex_op = 3'd0;
    run_busy(b, s);
    e = sb.pop_front();
    checks++;
    if (s != 0 || b != MULT_CYC || hi !== e.hi || lo !== e.lo) begin
      errors++; $display("FAIL nostall_run got stall=%0d busy=%0d %h_%h exp 0 %0d %h_%h",
                         s, b, hi, lo, MULT_CYC, e.hi, e.lo);
    end
    m_hi = e.hi; m_lo = e.lo;
  endtask

  task automatic test_back_to_back();
    int b, s;
    ex_op = 3'd2; ex_rs = 32'hFFFF_FFFF; ex_rt = 32'hFFFF_FFFF;
    sb.push_back('{32'hFFFF_FFFE, 32'h0000_0001});
    tick();
    ex_op = 3'd0;
    run_busy(b, s);
    e = sb.pop_front();
    checks++;
    if (hi !== e.hi || lo !== e.lo || b != MULT_CYC) begin
      errors++; $display("FAIL multu_result got %h_%h busy=%0d exp %h_%h", hi, lo, b, e.hi, e.lo);
    end
    // First IDLE cycle after completion accepts the next op.
    id_md_use = 1'b1;
    ex_op = 3'd4; ex_rs = 32'd7; ex_rt = 32'd2; #1;
    checks++;
    if (start !== 1'b1 || stall_md !== 1'b1) begin
      errors++; $display("FAIL b2b_start got start=%b stall=%b exp 1 1", start, stall_md);
    end
    sb.push_back('{32'd1, 32'd3});
    tick();
    ex_op = 3'd0;
    run_busy(b, s);
    e = sb.pop_front();
    checks++;
    if (hi !== e.hi || lo !== e.lo || b != DIV_CYC || s != DIV_CYC) begin
      errors++; $display("FAIL b2b_divu got %h_%h busy=%0d stall=%0d exp %h_%h %0d",
                         hi, lo, b, s, e.hi, e.lo, DIV_CYC);
    end
    m_hi = e.hi; m_lo = e.lo;
    id_md_use = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    ex_op = 3'd3; ex_rs = 32'd50; ex_rt = 32'd3;
    tick();
    ex_op = 3'd0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b exp 1", busy); end
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL midrst_clear got busy=%b %h_%h exp 0 0_0", busy, hi, lo);
    end
    m_hi = 32'd0; m_lo = 32'd0;
    sb.delete();
    tick();
    tick();
    reset = 1'b1;
    repeat (DIV_CYC + 3) tick();
    checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      errors++; $display("FAIL midrst_no_writeback got busy=%b %h_%h exp 0 %h_%h", busy, hi, lo, m_hi, m_lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu_stall();
    test_div();
    test_cancel();
    test_mt();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
